// File: rtl/class_arbiter_pkg.sv
// Shared definitions for the class arbiter: FSM encoding, class IDs and
// the default widths used by the class switching block.
package class_arbiter_pkg;

    localparam int DATA_SIZE_DEF = 10;
    localparam int MAIN_SIZE_DEF = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SERVE0 = 2'b01,
        SERVE1 = 2'b10
    } arb_state_e;

    localparam logic CLASS0 = 1'b0;
    localparam logic CLASS1 = 1'b1;

    // Service choice when leaving IDLE: alternate on a tie, otherwise take
    // whichever class has data.
    function automatic arb_state_e idle_pick(input logic empty0,
                                             input logic empty1,
                                             input logic last);
        arb_state_e nxt;
        nxt = IDLE;
        if (!empty0 && !empty1) begin
            nxt = (last == CLASS0) ? SERVE1 : SERVE0;
        end else if (!empty0) begin
            nxt = SERVE0;
        end else if (!empty1) begin
            nxt = SERVE1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/class_arbiter_pkt_counter.sv
// Wrapping event counter used for the per-class emitted-word counts.
module pkt_counter #(
    parameter int MAIN_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc_i,
    output logic [MAIN_SIZE-1:0] cnt_o
);

    logic [MAIN_SIZE-1:0] cnt_q;

    // Count one per enabled cycle, rolling over at the top of the range.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (inc_i) begin
            cnt_q <= cnt_q + MAIN_SIZE'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/class_arbiter.sv
// Weighted round-robin merge of the two class FIFOs onto one registered,
// class-tagged output stream with almost-full backpressure.
module class_arbiter
    import class_arbiter_pkg::*;
#(
    parameter int DATA_SIZE = DATA_SIZE_DEF,
    parameter int MAIN_SIZE = MAIN_SIZE_DEF,
    parameter int WEIGHT0   = 3,
    parameter int WEIGHT1   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fifo_empty0,
    input  logic                 fifo_empty1,
    input  logic [DATA_SIZE-1:0] in0,
    input  logic [DATA_SIZE-1:0] in1,
    input  logic                 down_almostfull,
    output logic                 pop_0,
    output logic                 pop_1,
    output logic [DATA_SIZE-1:0] data_out,
    output logic                 valid_out,
    output logic                 class_out,
    output logic [MAIN_SIZE-1:0] cnt0,
    output logic [MAIN_SIZE-1:0] cnt1
);

    localparam logic [3:0] W0 = 4'(WEIGHT0);
    localparam logic [3:0] W1 = 4'(WEIGHT1);

    arb_state_e           state_q, state_d;
    logic [3:0]           burst_q, burst_d;
    logic                 last_q, last_d;
    logic [3:0]           burst_inc;

    logic                 rd0_q, rd1_q;
    logic [DATA_SIZE-1:0] data_q;
    logic                 valid_q;
    logic                 class_q;

    assign burst_inc = burst_q + 4'd1;

    // Arbitration state, burst length and last-served class.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            burst_q <= 4'd0;
            last_q  <= CLASS1;
        end else begin
            state_q <= state_d;
            burst_q <= burst_d;
            last_q  <= last_d;
        end
    end

    // Next-state and pop strobes; almost-full freezes all arbitration state.
    always_comb begin
        state_d = state_q;
        burst_d = burst_q;
        last_d  = last_q;
        pop_0   = 1'b0;
        pop_1   = 1'b0;
        if (!down_almostfull) begin
            unique case (state_q)
                IDLE: begin
                    state_d = idle_pick(fifo_empty0, fifo_empty1, last_q);
                    burst_d = 4'd0;
                end
                SERVE0: begin
                    if (!fifo_empty0) begin
                        pop_0  = 1'b1;
                        last_d = CLASS0;
                        if (burst_inc == W0) begin
                            burst_d = 4'd0;
                            if (!fifo_empty1) begin
                                state_d = SERVE1;
                            end
                        end else begin
                            burst_d = burst_inc;
                        end
                    end else begin
                        burst_d = 4'd0;
                        state_d = fifo_empty1 ? IDLE : SERVE1;
                    end
                end
                SERVE1: begin
                    if (!fifo_empty1) begin
                        pop_1  = 1'b1;
                        last_d = CLASS1;
                        if (burst_inc == W1) begin
                            burst_d = 4'd0;
                            if (!fifo_empty0) begin
                                state_d = SERVE0;
                            end
                        end else begin
                            burst_d = burst_inc;
                        end
                    end else begin
                        burst_d = 4'd0;
                        state_d = fifo_empty0 ? IDLE : SERVE0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    burst_d = 4'd0;
                end
            endcase
        end
    end

    // Output stage: the delayed pop strobe picks which FIFO word to capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd0_q   <= 1'b0;
            rd1_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            class_q <= CLASS0;
        end else begin
            rd0_q   <= pop_0;
            rd1_q   <= pop_1;
            valid_q <= rd0_q | rd1_q;
            if (rd0_q) begin
                data_q  <= in0;
                class_q <= CLASS0;
            end else if (rd1_q) begin
                data_q  <= in1;
                class_q <= CLASS1;
            end
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign class_out = class_q;

    pkt_counter #(.MAIN_SIZE(MAIN_SIZE)) u_cnt0 (
        .clk   (clk),
        .rst   (reset),
        .inc_i (rd0_q),
        .cnt_o (cnt0)
    );

    pkt_counter #(.MAIN_SIZE(MAIN_SIZE)) u_cnt1 (
        .clk   (clk),
        .rst   (reset),
        .inc_i (rd1_q),
        .cnt_o (cnt1)
    );

endmodule

// File: tb/tb_class_arbiter.sv
// Bench for class_arbiter: queue-based FIFO models, a scheduling reference
// model and a scoreboard for the emitted words, plus directed scenarios.
module tb_class_arbiter;

    localparam int DW = 10;
    localparam int MW = 8;
    localparam int W0 = 3;
    localparam int W1 = 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          fe0, fe1, af;
    logic [DW-1:0] in0, in1;
    logic          pop_0, pop_1, valid_out, class_out;
    logic [DW-1:0] data_out;
    logic [MW-1:0] cnt0, cnt1;

    always #5 clk = ~clk;

    class_arbiter #(.DATA_SIZE(DW), .MAIN_SIZE(MW), .WEIGHT0(W0), .WEIGHT1(W1)) dut (
        .clk             (clk),
        .reset           (reset),
        .fifo_empty0     (fe0),
        .fifo_empty1     (fe1),
        .in0             (in0),
        .in1             (in1),
        .down_almostfull (af),
        .pop_0           (pop_0),
        .pop_1           (pop_1),
        .data_out        (data_out),
        .valid_out       (valid_out),
        .class_out       (class_out),
        .cnt0            (cnt0),
        .cnt1            (cnt1)
    );

    int            checks = 0;
    int            errors = 0;
    logic          mon_en = 1'b0;

    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];

    // Scheduler model: owner -1 = nobody, else the class being served.
    int            m_own, m_run, m_last;
    // Word popped at the last edge, and the word expected on the output now.
    logic          pend_v, pend_c, exp_v, exp_c;
    logic [DW-1:0] pend_d, exp_d;
    logic [MW-1:0] exp_n0, exp_n1;

    function automatic logic exp_pop(input int c);
        if (af || m_own != c) return 1'b0;
        return (c == 0) ? (q0.size() != 0) : (q1.size() != 0);
    endfunction

    task automatic model_reset();
        m_own  = -1; m_run = 0; m_last = 1;
        pend_v = 1'b0; pend_c = 1'b0; pend_d = '0;
        exp_v  = 1'b0; exp_c = 1'b0; exp_d = '0;
        exp_n0 = '0; exp_n1 = '0;
    endtask

    task automatic model_advance(input logic e0, input logic e1, input logic afb);
        int oth;
        logic ec, eo;
        if (afb) return;
        if (m_own < 0) begin
            if (!e0 && !e1) m_own = 1 - m_last;
            else if (!e0) m_own = 0;
            else if (!e1) m_own = 1;
            m_run = 0;
        end else begin
            oth = 1 - m_own;
            ec  = (m_own == 0) ? e0 : e1;
            eo  = (m_own == 0) ? e1 : e0;
            if (!ec) begin
                m_last = m_own;
                m_run++;
                if (m_run == ((m_own == 0) ? W0 : W1)) begin
                    m_run = 0;
                    if (!eo) m_own = oth;
                end
            end else begin
                m_run = 0;
                m_own = eo ? -1 : oth;
            end
        end
    endtask

    task automatic push0(input logic [DW-1:0] d);
        q0.push_back(d); fe0 = 1'b0;
    endtask

    task automatic push1(input logic [DW-1:0] d);
        q1.push_back(d); fe1 = 1'b0;
    endtask

    // One clock: FIFO models react to the pops, model advances.
    task automatic step();
        logic p0, p1, e0, e1, afb;
        p0  = exp_pop(0);
        p1  = exp_pop(1);
        e0  = (q0.size() == 0);
        e1  = (q1.size() == 0);
        afb = af;
        @(posedge clk);
        #1;
        exp_v = pend_v;
        exp_c = pend_c;
        if (pend_v) begin
            exp_d = pend_d;
            if (pend_c) exp_n1 = exp_n1 + MW'(1);
            else        exp_n0 = exp_n0 + MW'(1);
        end
        pend_v = p0 | p1;
        pend_c = p1;
        in0 = DW'($urandom);
        in1 = DW'($urandom);
        if (p0) begin pend_d = q0.pop_front(); in0 = pend_d; end
        if (p1) begin pend_d = q1.pop_front(); in1 = pend_d; end
        fe0 = (q0.size() == 0);
        fe1 = (q1.size() == 0);
        model_advance(e0, e1, afb);
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        reset  = 1'b1;
        af     = 1'b0;
        q0.delete(); q1.delete();
        fe0 = 1'b1; fe1 = 1'b1; in0 = '0; in1 = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        mon_en = 1'b1;
    endtask

    // Cycle-by-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        if (mon_en) begin
            logic p0, p1;
            p0 = exp_pop(0);
            p1 = exp_pop(1);
            checks++;
            if (pop_0 !== p0 || pop_1 !== p1) begin
                errors++;
                $display("FAIL mon_pops t=%0t got %b%b want %b%b", $time, pop_0, pop_1, p0, p1);
            end
            checks++;
            if (valid_out !== exp_v) begin
                errors++;
                $display("FAIL mon_valid t=%0t got %b want %b", $time, valid_out, exp_v);
            end
            if (exp_v) begin
                checks++;
                if (data_out !== exp_d || class_out !== exp_c) begin
                    errors++;
                    $display("FAIL mon_word t=%0t got %h/%b want %h/%b", $time, data_out, class_out, exp_d, exp_c);
                end
            end
            checks++;
            if (cnt0 !== exp_n0 || cnt1 !== exp_n1) begin
                errors++;
                $display("FAIL mon_cnt t=%0t got %0d/%0d want %0d/%0d", $time, cnt0, cnt1, exp_n0, exp_n1);
            end
        end
    end

    task automatic test_reset();
        reset = 1'b0; af = 1'b0; fe0 = 1'b1; fe1 = 1'b1; in0 = '0; in1 = '0;
        model_reset();
        #1 reset = 1'b1;
        #2;
        checks++; if (pop_0 !== 1'b0 || pop_1 !== 1'b0) begin errors++; $display("FAIL reset_pops got %b%b want 00", pop_0, pop_1); end
        checks++; if (data_out !== '0) begin errors++; $display("FAIL reset_data got %h want 0", data_out); end
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid_out); end
        checks++; if (class_out !== 1'b0) begin errors++; $display("FAIL reset_class got %b want 0", class_out); end
        checks++; if (cnt0 !== '0 || cnt1 !== '0) begin errors++; $display("FAIL reset_cnt got %0d/%0d want 0/0", cnt0, cnt1); end
        fe0 = 1'b0;
        @(posedge clk); #1;
        checks++; if (pop_0 !== 1'b0) begin errors++; $display("FAIL reset_hold_pop got %b want 0", pop_0); end
        fe0 = 1'b1;
    endtask

    task automatic test_class0_only();
        do_reset();
        for (int i = 0; i < 4; i++) push0(DW'(32'h011 + i));
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (pop_0 !== (c >= 1 && c <= 4) || pop_1 !== 1'b0) begin
                errors++; $display("FAIL c0only_pop cyc=%0d got %b%b", c, pop_0, pop_1);
            end
            checks++;
            if (valid_out !== (c >= 3 && c <= 6)) begin
                errors++; $display("FAIL c0only_valid cyc=%0d got %b", c, valid_out);
            end
            if (c >= 3 && c <= 6) begin
                checks++;
                if (data_out !== DW'(32'h011 + c - 3) || class_out !== 1'b0) begin
                    errors++; $display("FAIL c0only_word cyc=%0d got %h/%b want %h/0", c, data_out, class_out, DW'(32'h011 + c - 3));
                end
            end
            step();
        end
        checks++; if (cnt0 !== MW'(4)) begin errors++; $display("FAIL c0only_cnt0 got %0d want 4", cnt0); end
    endtask

    task automatic test_wrr();
        int            cls[$];
        logic [DW-1:0] d0[$];
        logic [DW-1:0] d1[$];
        int            exp_cls[16] = '{0,0,0,1,0,0,0,1,0,0,1,1,1,1,1,1};
        int            lastc, nv, gaps;
        lastc = 0; nv = 0; gaps = 0;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            push0(DW'(32'h100 + i));
            push1(DW'(32'h200 + i));
        end
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (valid_out) begin
                cls.push_back(int'(class_out));
                if (class_out) d1.push_back(data_out); else d0.push_back(data_out);
                if (nv > 0 && nv < 10 && c != lastc + 1) gaps++;
                lastc = c;
                nv++;
            end
            step();
        end
        checks++; if (cls.size() != 16) begin errors++; $display("FAIL wrr_count got %0d want 16", cls.size()); end
        for (int i = 0; i < 16; i++) begin
            if (i < cls.size()) begin
                checks++;
                if (cls[i] != exp_cls[i]) begin errors++; $display("FAIL wrr_class idx=%0d got %0d want %0d", i, cls[i], exp_cls[i]); end
            end
        end
        for (int i = 0; i < 8; i++) begin
            if (i < d0.size() && i < d1.size()) begin
                checks++;
                if (d0[i] !== DW'(32'h100 + i) || d1[i] !== DW'(32'h200 + i)) begin
                    errors++; $display("FAIL wrr_order idx=%0d got %h/%h want %h/%h", i, d0[i], d1[i], DW'(32'h100 + i), DW'(32'h200 + i));
                end
            end
        end
        checks++; if (gaps != 0) begin errors++; $display("FAIL wrr_bubbles got %0d want 0", gaps); end
        checks++; if (cnt0 !== MW'(8) || cnt1 !== MW'(8)) begin errors++; $display("FAIL wrr_cnt got %0d/%0d want 8/8", cnt0, cnt1); end
    endtask

    task automatic test_backpressure();
        int nv, bad;
        nv = 0; bad = 0;
        do_reset();
        for (int i = 0; i < 6; i++) push0(DW'(32'h140 + i));
        for (int i = 0; i < 4; i++) push1(DW'(32'h240 + i));
        for (int c = 0; c < 13; c++) begin
            af = (c >= 3 && c <= 7);
            @(negedge clk);
            if (c >= 3 && c <= 9 && valid_out) nv++;
            if (af && (pop_0 || pop_1)) bad++;
            if (c == 8) begin
                checks++;
                if (pop_0 !== 1'b1 || pop_1 !== 1'b0) begin errors++; $display("FAIL bp_resume0 got %b%b want 10", pop_0, pop_1); end
            end
            if (c == 9) begin
                checks++;
                if (pop_0 !== 1'b0 || pop_1 !== 1'b1) begin errors++; $display("FAIL bp_switch1 got %b%b want 01", pop_0, pop_1); end
            end
            step();
        end
        af = 1'b0;
        checks++; if (nv != 2) begin errors++; $display("FAIL bp_inflight got %0d want 2", nv); end
        checks++; if (bad != 0) begin errors++; $display("FAIL bp_pop_while_af got %0d want 0", bad); end
    endtask

    task automatic test_drain_midburst();
        int bad;
        bad = 0;
        do_reset();
        for (int i = 0; i < 2; i++) push0(DW'(32'h150 + i));
        for (int i = 0; i < 3; i++) push1(DW'(32'h250 + i));
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            if ((pop_0 && fe0) || (pop_1 && fe1)) bad++;
            if (c == 3) begin
                checks++;
                if (pop_0 !== 1'b0 || pop_1 !== 1'b0) begin errors++; $display("FAIL drain_gap got %b%b want 00", pop_0, pop_1); end
            end
            if (c == 4) begin
                checks++;
                if (pop_1 !== 1'b1) begin errors++; $display("FAIL drain_switch got %b want 1", pop_1); end
            end
            step();
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL drain_pop_empty got %0d want 0", bad); end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        for (int i = 0; i < 6; i++) push0(DW'(32'h031 + i));
        for (int c = 0; c < 4; c++) step();
        mon_en = 1'b0;
        #1;
        checks++;
        if (valid_out !== 1'b1 || data_out !== DW'(32'h032)) begin
            errors++; $display("FAIL rst_mid_before got %b/%h want 1/032", valid_out, data_out);
        end
        #1 reset = 1'b1;
        #1;
        checks++; if (valid_out !== 1'b0 || data_out !== '0) begin errors++; $display("FAIL rst_mid_out got %b/%h want 0/000", valid_out, data_out); end
        checks++; if (cnt0 !== '0 || cnt1 !== '0) begin errors++; $display("FAIL rst_mid_cnt got %0d/%0d want 0/0", cnt0, cnt1); end
        checks++; if (pop_0 !== 1'b0 || pop_1 !== 1'b0) begin errors++; $display("FAIL rst_mid_pops got %b%b want 00", pop_0, pop_1); end
        q0.delete(); q1.delete(); fe0 = 1'b1; fe1 = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        mon_en = 1'b1;
        push0(DW'(32'h061)); push0(DW'(32'h062));
        push1(DW'(32'h261)); push1(DW'(32'h262));
        step();
        @(negedge clk);
        checks++; if (pop_0 !== 1'b1 || pop_1 !== 1'b0) begin errors++; $display("FAIL rst_mid_tie got %b%b want 10", pop_0, pop_1); end
        for (int c = 0; c < 10; c++) step();
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 257; i++) push1(DW'(i));
        for (int c = 0; c < 265; c++) step();
        checks++; if (cnt1 !== MW'(1) || cnt0 !== '0) begin errors++; $display("FAIL wrap_cnt got %0d/%0d want 0/1", cnt0, cnt1); end
    endtask

    task automatic test_random();
        int p0r, p1r, afr;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            case ((i / 500) % 3)
                0:       begin p0r = 2; p1r = 2; afr = 5; end
                1:       begin p0r = 1; p1r = 4; afr = 3; end
                default: begin p0r = 5; p1r = 1; afr = 8; end
            endcase
            if ($urandom_range(0, p0r) == 0) push0(DW'($urandom));
            if ($urandom_range(0, p1r) == 0) push1(DW'($urandom));
            af = ($urandom_range(0, afr) == 0);
            step();
        end
        af = 1'b0;
        for (int c = 0; c < 40; c++) step();
        checks++; if (q0.size() != 0 || q1.size() != 0) begin errors++; $display("FAIL rand_drain got %0d/%0d want 0/0", q0.size(), q1.size()); end
    endtask

    initial begin
        test_reset();
        test_class0_only();
        test_wrr();
        test_backpressure();
        test_drain_midburst();
        test_reset_midflight();
        test_wrap();
        test_random();
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
